// File: rtl/lif_neuron_array_if.sv
// Bus bundle for lif_neuron_array: step/config inputs and the registered
// spike, membrane and counter outputs that feed the top-level I/O mux.
interface lif_neuron_array_if #(
    parameter int N_NEURONS = 4,
    parameter int W         = 8,
    parameter int CNT_W     = 16
);
    logic                   step_i;
    logic [N_NEURONS*W-1:0] current_i;
    logic [W-1:0]           thresh_i;
    logic                   reset_mode_i;
    logic                   cnt_clr_i;
    logic [N_NEURONS-1:0]   spike_o;
    logic [N_NEURONS*W-1:0] state_o;
    logic                   spike_any_o;
    logic [CNT_W-1:0]       spike_cnt_o;
    logic                   step_done_o;

    modport master (
        output step_i, current_i, thresh_i, reset_mode_i, cnt_clr_i,
        input  spike_o, state_o, spike_any_o, spike_cnt_o, step_done_o
    );

    modport slave (
        input  step_i, current_i, thresh_i, reset_mode_i, cnt_clr_i,
        output spike_o, state_o, spike_any_o, spike_cnt_o, step_done_o
    );
endinterface

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons updated in parallel on each time
// step, with per-neuron refractory timers and a saturating spike counter.
module lif_neuron_array #(
    parameter int N_NEURONS    = 4,
    parameter int W            = 8,
    parameter int LEAK_SHIFT   = 1,
    parameter int REFRAC_STEPS = 2,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         rst,
    lif_neuron_array_if.slave bus
);
    localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
    localparam int AW = ((CNT_W > 5) ? CNT_W : 5) + 1;
    localparam logic [RW-1:0] REFRAC_L = RW'(REFRAC_STEPS);

    function automatic logic [4:0] popcount(input logic [N_NEURONS-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < N_NEURONS; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    logic [W-1:0]         state_r      [N_NEURONS];
    logic [RW-1:0]        refrac_r     [N_NEURONS];
    logic [N_NEURONS-1:0] spike_r;
    logic                 spike_any_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 step_done_r;

    logic [W-1:0]         decay_s      [N_NEURONS];
    logic [W-1:0]         drive_s      [N_NEURONS];
    logic [W:0]           sum_s        [N_NEURONS];
    logic [W-1:0]         integ_s      [N_NEURONS];
    logic [W-1:0]         state_nxt_s  [N_NEURONS];
    logic [RW-1:0]        refrac_nxt_s [N_NEURONS];
    logic [N_NEURONS-1:0] fire_s;
    logic [AW-1:0]        cnt_sum_s;
    logic [CNT_W-1:0]     cnt_nxt_s;

    // Per-neuron leak, integrate with saturation, fire decision and next state.
    always_comb begin
        fire_s = {N_NEURONS{1'b0}};
        for (int k = 0; k < N_NEURONS; k++) begin
            decay_s[k] = state_r[k] - (state_r[k] >> LEAK_SHIFT);
            if (refrac_r[k] == {RW{1'b0}}) begin
                drive_s[k] = bus.current_i[k*W +: W];
            end else begin
                drive_s[k] = {W{1'b0}};
            end
            sum_s[k] = {1'b0, decay_s[k]} + {1'b0, drive_s[k]};
            if (sum_s[k][W]) begin
                integ_s[k] = {W{1'b1}};
            end else begin
                integ_s[k] = sum_s[k][W-1:0];
            end
            fire_s[k] = (refrac_r[k] == {RW{1'b0}}) && (integ_s[k] >= bus.thresh_i);
            if (fire_s[k]) begin
                state_nxt_s[k]  = bus.reset_mode_i ? (integ_s[k] - bus.thresh_i) : {W{1'b0}};
                refrac_nxt_s[k] = REFRAC_L;
            end else if (refrac_r[k] != {RW{1'b0}}) begin
                state_nxt_s[k]  = integ_s[k];
                refrac_nxt_s[k] = refrac_r[k] - {{(RW-1){1'b0}}, 1'b1};
            end else begin
                state_nxt_s[k]  = integ_s[k];
                refrac_nxt_s[k] = refrac_r[k];
            end
        end
    end

    // Counter add uses this step's spikes so the count moves with spike_o.
    always_comb begin
        cnt_sum_s = AW'(cnt_r) + AW'(popcount(fire_s));
        if (cnt_sum_s > AW'({CNT_W{1'b1}})) begin
            cnt_nxt_s = {CNT_W{1'b1}};
        end else begin
            cnt_nxt_s = cnt_sum_s[CNT_W-1:0];
        end
    end

    // Neuron state, refractory timers and the one-cycle output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                state_r[k]  <= {W{1'b0}};
                refrac_r[k] <= {RW{1'b0}};
            end
            spike_r     <= {N_NEURONS{1'b0}};
            spike_any_r <= 1'b0;
            step_done_r <= 1'b0;
        end else if (bus.step_i) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                state_r[k]  <= state_nxt_s[k];
                refrac_r[k] <= refrac_nxt_s[k];
            end
            spike_r     <= fire_s;
            spike_any_r <= |fire_s;
            step_done_r <= 1'b1;
        end else begin
            spike_r     <= {N_NEURONS{1'b0}};
            spike_any_r <= 1'b0;
            step_done_r <= 1'b0;
        end
    end

    // Aggregate spike counter; a clear discards spikes of the same step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (bus.cnt_clr_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (bus.step_i) begin
            cnt_r <= cnt_nxt_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_state_out
        assign bus.state_o[g*W +: W] = state_r[g];
    end

    assign bus.spike_o     = spike_r;
    assign bus.spike_any_o = spike_any_r;
    assign bus.spike_cnt_o = cnt_r;
    assign bus.step_done_o = step_done_r;
endmodule
